uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Buffered feeder placed directly upstream of uart_tx.
- Accepts bytes from a producer (e.g. uart_rx echo path, CPU bridge) with a valid/ready handshake and stores them in a synchronous FIFO.
- Issues one single-cycle i_data_valid pulse to uart_tx per byte, then waits for uart_tx's o_busy to rise and fall before issuing the next.
- Removes byte loss when the producer bursts faster than the line rate.

Parameters:
- DATA_BITS, 8, byte width; must match uart_tx DATA_BITS.
- DEPTH, 16, FIFO entries; power of two, >= 2.
- ACK_CYCLES, 2, max cycles to wait for i_tx_busy to rise after a pulse before giving up.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- i_data_valid  in  1  producer byte valid
- i_data  in  DATA_BITS  producer byte
- o_ready  out  1  FIFO not full
- o_tx_data_valid  out  1  one-cycle pulse to uart_tx i_data_valid
- o_tx_data  out  DATA_BITS  byte to uart_tx i_data; held stable until the next pulse
- i_tx_busy  in  1  uart_tx o_busy
- o_count  out  $clog2(DEPTH)+1  current occupancy
- o_empty  out  1  count == 0
- o_full  out  1  count == DEPTH
- o_overflow  out  1  sticky: a write was dropped

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. All state updates on posedge clk.
- Reset clears pointers, count, FSM and the overflow flag.
- Output values at reset:
  - o_count=0, o_empty=1, o_full=0, o_ready=1.
  - o_tx_data_valid=0, o_tx_data=0, o_overflow=0.
- Reset mid-operation discards all buffered bytes. A byte already handed to uart_tx is not recalled.
- Write rules:
  - A write is accepted when i_data_valid && !o_full.
  - An accepted byte is stored at the write pointer; the pointer wraps DEPTH-1 -> 0.
  - When i_data_valid && o_full, the byte is dropped and o_overflow is set, sticky until rst.
  - Fullness is judged on the current-cycle flag: a push while full is dropped even if a pop happens in the same cycle.
- Count update per cycle:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged
  - o_empty, o_full and o_ready are derived combinationally from the registered count.
- FSM states: IDLE, WAIT_ACK, WAIT_DONE.
  - IDLE: if !o_empty && !i_tx_busy, pop the head. Next cycle, o_tx_data=head and o_tx_data_valid=1 for exactly one cycle. Go to WAIT_ACK and clear the ack counter.
  - WAIT_ACK: if i_tx_busy, go to WAIT_DONE. Otherwise increment the ack counter; when it reaches ACK_CYCLES, return to IDLE. The byte counts as issued; no retry.
  - WAIT_DONE: when i_tx_busy==0, go to IDLE.
- Latency:
  - A byte written in cycle N into an empty FIFO with uart_tx idle gives o_tx_data_valid=1 in cycle N+2.
  - Back-to-back bytes go out one per uart_tx frame, with at most 2 idle cycles between the busy fall and the next pulse.
- Pop happens only in IDLE, so there is never more than one byte in flight.
- i_tx_busy already high in IDLE (uart_tx busy from another source): hold in IDLE until it drops.
- Count wrap: the count never exceeds DEPTH, and underflow is impossible because pop requires !o_empty.

Optional Feature:
- Macro: UART_TX_FIFO_STATS_EN.
- Defined adds two outputs:
  - o_drop_count, 16 bits: increments on each dropped write, saturates at 0xFFFF.
  - o_max_level, $clog2(DEPTH)+1 bits: high-water mark of o_count.
  - Both reset to 0 on rst.
- Undefined: these ports and their registers do not exist. All other behaviour is identical.

Decomposition:
- Package uart_pkg holds:
  - the FSM state enum uart_tx_fifo_state_t {IDLE, WAIT_ACK, WAIT_DONE}
  - the default DATA_BITS constant shared with uart_rx/uart_tx.
- One sub-module, sync_fifo: storage array, read/write pointers, count and full/empty logic, with push/pop/data ports.
- uart_tx_fifo keeps the FSM, pulse generation, overflow flag and stats.

Test Plan:
- Single byte: write 0x5A while idle, with a uart_tx model asserting busy 1 cycle after the pulse for 20 cycles. Required: pulse at N+2 with o_tx_data=0x5A; o_empty returns to 1; no second pulse.
- Burst: write 0x00..0x0F on consecutive cycles (DEPTH=16). Required: o_full never drops data; o_ready low only while count==16; uart_tx model receives 0x00..0x0F in order, one pulse per busy low-high-low cycle.
- Overflow: fill 16 bytes with busy held high, then write 0xAA. Required: 0xAA dropped; o_overflow=1 and stays 1; with STATS_EN, o_drop_count=1 and o_max_level=16.
- Ack timeout: write 0x33 while the model never raises busy. Required: one pulse, then FSM back in IDLE after 2 cycles; the next byte 0x44 is pulsed without hang.
- Simultaneous push/pop: with count=3, push 0x77 in the same cycle as an IDLE pop. Required: count stays 3; 0x77 emerges after the three earlier bytes.
- Reset mid-stream: assert rst with count=5 while in WAIT_DONE. Required: next cycle count=0, o_empty=1, o_tx_data_valid=0, o_overflow=0; no further pulses until a new write.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART block family (uart_rx, uart_tx, uart_tx_fifo).
//   UART_DATA_BITS        default character width used by every UART block
//   uart_tx_fifo_state_t  state encoding of the uart_tx_fifo issue FSM
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,  // waiting for a buffered byte and an idle uart_tx
        WAIT_ACK  = 2'd1,  // pulse issued, waiting for uart_tx to go busy
        WAIT_DONE = 2'd2   // uart_tx is shifting the byte out
    } uart_tx_fifo_state_t;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_if
// Producer-side byte stream into uart_tx_fifo (valid/ready handshake).
//   data_valid  producer has a byte this cycle
//   data        the byte
//   ready       consumer can accept (FIFO not full)
// Modports: master = producer, slave = uart_tx_fifo.
// -----------------------------------------------------------------------------
interface uart_tx_fifo_if
    import uart_pkg::*;
#(
    parameter int DATA_BITS = UART_DATA_BITS
);

    logic                 data_valid;
    logic [DATA_BITS-1:0] data;
    logic                 ready;

    modport master (output data_valid, output data, input ready);
    modport slave  (input data_valid, input data, output ready);

endinterface

// File: rtl/uart_tx_fifo_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with a combinational head read (first-word fall-through).
//   clk, rst   clock, synchronous active-high reset
//   i_push     write i_wdata (ignored while full)
//   i_wdata    write data
//   i_pop      discard the head entry (ignored while empty)
//   o_rdata    current head entry
//   o_count    occupancy, 0..DEPTH
//   o_empty    o_count == 0
//   o_full     o_count == DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [DATA_BITS-1:0]   i_wdata,
    input  logic                   i_pop,
    output logic [DATA_BITS-1:0]   o_rdata,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_empty,
    output logic                   o_full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [DATA_BITS-1:0] r_mem [DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [CW-1:0]        r_count;
    logic                 w_push;
    logic                 w_pop;

    // Fullness is judged on the registered count, so a push while full is
    // refused even when a pop frees a slot in the same cycle.
    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    // NOTE: storage has no reset; the pointers and count alone define which
    // entries are valid, and leaving the array unreset lets it map onto RAM.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == FULL_COUNT);

endmodule

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Buffered feeder for uart_tx: bytes from a producer are queued in a FIFO and
// handed to uart_tx one at a time as a single-cycle pulse, waiting for the
// uart_tx busy flag to rise and fall between bytes.
//   clk, rst          clock, synchronous active-high reset
//   in_if (slave)     producer stream: data_valid, data, ready (= not full)
//   o_tx_data_valid   one-cycle pulse to uart_tx i_data_valid
//   o_tx_data         byte to uart_tx i_data, held until the next pulse
//   i_tx_busy         uart_tx o_busy
//   o_count           FIFO occupancy
//   o_empty, o_full   occupancy flags
//   o_overflow        sticky: a write arrived while full and was dropped
// Optional (macro UART_TX_FIFO_STATS_EN):
//   o_drop_count      saturating count of dropped writes
//   o_max_level       high-water mark of o_count
// -----------------------------------------------------------------------------
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int DEPTH      = 16,
    parameter int ACK_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    uart_tx_fifo_if.slave          in_if,
    output logic                   o_tx_data_valid,
    output logic [DATA_BITS-1:0]   o_tx_data,
    input  logic                   i_tx_busy,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_empty,
    output logic                   o_full,
    output logic                   o_overflow
`ifdef UART_TX_FIFO_STATS_EN
    ,
    output logic [15:0]            o_drop_count,
    output logic [$clog2(DEPTH):0] o_max_level
`endif
);

    localparam int CW  = $clog2(DEPTH) + 1;
    localparam int ACW = $clog2(ACK_CYCLES + 1);
    localparam logic [ACW-1:0] ACK_LAST = ACW'(ACK_CYCLES - 1);

    uart_tx_fifo_state_t  r_state;
    logic [ACW-1:0]       r_ack_cnt;
    logic                 r_tx_valid;
    logic [DATA_BITS-1:0] r_tx_data;
    logic                 r_overflow;

    logic [DATA_BITS-1:0] w_head;
    logic [CW-1:0]        w_count;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_drop;

    // Popping only from IDLE keeps at most one byte in flight to uart_tx.
    assign w_pop  = (r_state == IDLE) && !w_empty && !i_tx_busy;
    assign w_drop = in_if.data_valid && w_full;

    sync_fifo #(
        .DATA_BITS (DATA_BITS),
        .DEPTH     (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (in_if.data_valid),
        .i_wdata (in_if.data),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_count (w_count),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_ack_cnt  <= '0;
            r_tx_valid <= 1'b0;
            r_tx_data  <= '0;
        end else begin
            r_tx_valid <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_tx_data  <= w_head;
                        r_tx_valid <= 1'b1;
                        r_ack_cnt  <= '0;
                        r_state    <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    // A byte whose busy never rises is considered issued;
                    // there is no retry.
                    if (i_tx_busy) begin
                        r_state <= WAIT_DONE;
                    end else begin
                        r_ack_cnt <= r_ack_cnt + 1'b1;
                        if (r_ack_cnt == ACK_LAST) r_state <= IDLE;
                    end
                end
                WAIT_DONE: begin
                    if (!i_tx_busy) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

`ifdef UART_TX_FIFO_STATS_EN
    logic [15:0]   r_drop_count;
    logic [CW-1:0] r_max_level;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_count <= '0;
            r_max_level  <= '0;
        end else begin
            if (w_drop && (r_drop_count != 16'hFFFF)) r_drop_count <= r_drop_count + 1'b1;
            if (w_count > r_max_level)                r_max_level  <= w_count;
        end
    end

    assign o_drop_count = r_drop_count;
    assign o_max_level  = r_max_level;
`endif

    assign in_if.ready     = !w_full;
    assign o_tx_data_valid = r_tx_valid;
    assign o_tx_data       = r_tx_data;
    assign o_count         = w_count;
    assign o_empty         = w_empty;
    assign o_full          = w_full;
    assign o_overflow      = r_overflow;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
// Scoreboard bench for uart_tx_fifo (DEPTH=16, ACK_CYCLES=2). Accepted bytes are
// queued when written; a monitor pops and compares on every o_tx_data_valid.
// A small uart_tx model raises busy one cycle after each pulse for busy_len
// cycles; force_busy holds busy high independently.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       o_tx_data_valid;
    logic [7:0] o_tx_data;
    logic       i_tx_busy;
    logic [4:0] o_count;
    logic       o_empty;
    logic       o_full;
    logic       o_overflow;
`ifdef UART_TX_FIFO_STATS_EN
    logic [15:0] o_drop_count;
    logic [4:0]  o_max_level;
`endif

    uart_tx_fifo_if #(.DATA_BITS(8)) u_if ();

    uart_tx_fifo #(
        .DATA_BITS  (8),
        .DEPTH      (16),
        .ACK_CYCLES (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .in_if           (u_if),
        .o_tx_data_valid (o_tx_data_valid),
        .o_tx_data       (o_tx_data),
        .i_tx_busy       (i_tx_busy),
        .o_count         (o_count),
        .o_empty         (o_empty),
        .o_full          (o_full),
        .o_overflow      (o_overflow)
`ifdef UART_TX_FIFO_STATS_EN
        ,
        .o_drop_count    (o_drop_count),
        .o_max_level     (o_max_level)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int wr_cyc = 0;
    int last_pulse = 0;
    int prev_pulse = 0;
    int n_pulses = 0;
    logic [7:0] exp_q [$];

    // uart_tx model
    logic model_en;
    logic force_busy;
    int   busy_len;
    int   busy_left = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (model_en && o_tx_data_valid) busy_left <= busy_len;
        else if (busy_left > 0)          busy_left <= busy_left - 1;
    end
    assign i_tx_busy = force_busy || (busy_left != 0);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: scoreboard compare on every pulse, plus flag consistency.
    always @(negedge clk) begin
        if (!rst) begin
            check("ready_vs_count", u_if.ready, (o_count != 5'd16));
            check("empty_vs_count", o_empty, (o_count == 5'd0));
            if (o_tx_data_valid) begin
                prev_pulse = last_pulse;
                last_pulse = cyc;
                n_pulses++;
                check("busy_low_at_pulse", i_tx_busy, 1'b0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL spurious_pulse: got data 0x%0h, want no pulse (cycle %0d)", o_tx_data, cyc);
                end else begin
                    check("tx_data", o_tx_data, exp_q.pop_front());
                end
            end
        end
    end

    task automatic send(input logic [7:0] b, input bit dropped);
        @(posedge clk);
        #1;
        u_if.data_valid = 1'b1;
        u_if.data       = b;
        wr_cyc          = cyc;
        if (!dropped) exp_q.push_back(b);
    endtask

    task automatic idle(input int n);
        @(posedge clk);
        #1;
        u_if.data_valid = 1'b0;
        repeat (n - 1) @(posedge clk);
    endtask

    task automatic wait_drain(input string name, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(posedge clk);
        check({"drain_", name}, exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        rst             = 1'b1;
        u_if.data_valid = 1'b0;
        u_if.data       = '0;
        model_en        = 1'b1;
        force_busy      = 1'b0;
        busy_len        = 20;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_count",    o_count, 0);
        check("rst_empty",    o_empty, 1);
        check("rst_full",     o_full, 0);
        check("rst_ready",    u_if.ready, 1);
        check("rst_tx_valid", o_tx_data_valid, 0);
        check("rst_tx_data",  o_tx_data, 8'h00);
        check("rst_overflow", o_overflow, 0);

        // Single byte: pulse two cycles after the write, then nothing else
        p0 = n_pulses;
        send(8'h5A, 0);
        idle(30);
        wait_drain("single", 10);
        check("single_latency", last_pulse - wr_cyc, 2);
        check("single_empty", o_empty, 1);
        check("single_pulses", n_pulses - p0, 1);

        // Burst 0x00..0x0F with a short uart_tx frame
        busy_len = 3;
        p0 = n_pulses;
        for (int i = 0; i < 16; i++) send(8'(i), 0);
        idle(1);
        wait_drain("burst", 300);
        check("burst_pulses", n_pulses - p0, 16);
        check("burst_no_overflow", o_overflow, 0);
        idle(10);

        // Overflow: fill while uart_tx is held busy, then one more byte
        force_busy = 1'b1;
        for (int i = 0; i < 16; i++) send(8'h10 + 8'(i), 0);
        send(8'hAA, 1);
        idle(2);
        @(negedge clk);
        check("ovf_count", o_count, 16);
        check("ovf_full", o_full, 1);
        check("ovf_ready", u_if.ready, 0);
        check("ovf_flag", o_overflow, 1);
`ifdef UART_TX_FIFO_STATS_EN
        check("ovf_drop_count", o_drop_count, 1);
        check("ovf_max_level", o_max_level, 16);
`endif
        // Push while full in the same cycle as a pop: still dropped
        @(posedge clk);
        #1;
        force_busy      = 1'b0;
        u_if.data_valid = 1'b1;
        u_if.data       = 8'hBB;
        idle(1);
        @(negedge clk);
        check("full_pushpop_count", o_count, 15);
        wait_drain("overflow", 400);
        check("ovf_sticky", o_overflow, 1);
`ifdef UART_TX_FIFO_STATS_EN
        check("ovf_drop_count2", o_drop_count, 2);
`endif
        idle(10);

        // Ack timeout: uart_tx never goes busy
        model_en = 1'b0;
        send(8'h33, 0);
        send(8'h44, 0);
        idle(1);
        wait_drain("ack_timeout", 20);
        check("ack_timeout_gap", last_pulse - prev_pulse, 3);
        model_en = 1'b1;
        idle(10);

        // Simultaneous push and pop with three bytes queued
        force_busy = 1'b1;
        send(8'h61, 0);
        send(8'h62, 0);
        send(8'h63, 0);
        idle(1);
        @(negedge clk);
        check("pp_count_before", o_count, 3);
        @(posedge clk);
        #1;
        force_busy = 1'b0;
        u_if.data_valid = 1'b1;
        u_if.data       = 8'h77;
        exp_q.push_back(8'h77);
        idle(1);
        @(negedge clk);
        check("pp_count_after", o_count, 3);
        wait_drain("pushpop", 200);
        idle(10);

        // Reset while uart_tx is busy with five bytes still queued
        busy_len = 20;
        for (int i = 0; i < 6; i++) send(8'hA1 + 8'(i), 0);
        idle(3);
        @(negedge clk);
        check("mid_count", o_count, 5);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_count", o_count, 0);
        check("mid_rst_empty", o_empty, 1);
        check("mid_rst_tx_valid", o_tx_data_valid, 0);
        check("mid_rst_overflow", o_overflow, 0);
`ifdef UART_TX_FIFO_STATS_EN
        check("mid_rst_drop_count", o_drop_count, 0);
        check("mid_rst_max_level", o_max_level, 0);
`endif
        p0 = n_pulses;
        idle(40);
        check("mid_rst_no_pulse", n_pulses - p0, 0);
        send(8'h99, 0);
        idle(1);
        wait_drain("after_reset", 60);
        check("after_reset_pulses", n_pulses - p0, 1);

        idle(5);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
